// File: rtl/etomux_seq_driver_if.sv
// Byte-in / bit-out handshake bundle for the etomux sequencer,
// including the mux data/select/output wires.
interface etomux_seq_driver_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] mux_a;
   logic [2:0] mux_s;
   logic       mux_q;
   logic       out_bit;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       out_parity;

   modport master (
      output in_valid, in_data, mux_q, out_ready,
      input  in_ready, mux_a, mux_s,
      input  out_bit, out_valid, out_last, out_parity
   );

   modport slave (
      input  in_valid, in_data, mux_q, out_ready,
      output in_ready, mux_a, mux_s,
      output out_bit, out_valid, out_last, out_parity
   );
endinterface

// File: rtl/etomux_seq_driver.sv
// Byte serializer: holds a byte on the 8:1 mux inputs and walks the
// select, streaming each mux output bit with last flag and even parity.
module etomux_seq_driver #(
   parameter bit MSB_FIRST = 1'b0
) (
   input logic clk,
   input logic rst,
   etomux_seq_driver_if.slave bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   localparam logic [2:0] S_START = MSB_FIRST ? 3'd7 : 3'd0;

   logic [0:0] state;
   logic [2:0] cnt;
   logic       par;
   logic [7:0] a;
   logic [2:0] s;
   logic       in_fire;
   logic       out_fire;
   logic       at_last;

   assign at_last  = (cnt == 3'd7);
   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a     <= 8'h00;
         s     <= 3'd0;
         cnt   <= 3'd0;
         par   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_fire) begin
                  a     <= bus.in_data;
                  s     <= S_START;
                  cnt   <= 3'd0;
                  par   <= 1'b0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (out_fire) begin
                  // a and s are left as-is on exit so the mux stays quiet
                  if (at_last) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 3'd1;
                     s   <= MSB_FIRST ? s - 3'd1 : s + 3'd1;
                     par <= par ^ bus.mux_q;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake outputs are masked while reset is held
   assign bus.in_ready   = !rst && (state == IDLE);
   assign bus.out_valid  = !rst && (state == SEND);
   assign bus.out_last   = bus.out_valid && at_last;
   assign bus.out_parity = bus.out_last && (par ^ bus.mux_q);
   assign bus.out_bit    = bus.mux_q;
   assign bus.mux_a      = a;
   assign bus.mux_s      = s;

endmodule

// File: tb/tb_etomux_seq_driver.sv
// Scoreboard bench for etomux_seq_driver with a behavioural 8:1 mux,
// one LSB-first and one MSB-first instance.
module tb_etomux_seq_driver;

   typedef logic [5:0] exp_t;

   logic clk;
   logic rst;
   int   ok;
   int   total;
   exp_t q0[$];
   exp_t q1[$];

   etomux_seq_driver_if bus0 ();
   etomux_seq_driver_if bus1 ();

   assign bus0.mux_q = bus0.mux_a[bus0.mux_s];
   assign bus1.mux_q = bus1.mux_a[bus1.mux_s];

   etomux_seq_driver #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk),
      .rst(rst),
      .bus(bus0.slave)
   );

   etomux_seq_driver #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk),
      .rst(rst),
      .bus(bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {bit, last, parity, select} for beat i of byte v
   function automatic exp_t beat(input logic [7:0] v, input bit msb,
                                 input int i);
      logic [2:0] s;
      logic       l;
      logic       p;
      s = msb ? 3'(7 - i) : 3'(i);
      l = (i == 7);
      p = l ? ^v : 1'b0;
      return {v[s], l, p, s};
   endfunction

   task automatic offer0(input logic [7:0] v);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus0.in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!bus0.in_ready) begin
         total++;
         $display("FAIL offer0_timeout in_ready=%b required 1",
                  bus0.in_ready);
      end
      bus0.in_valid = 1'b1;
      bus0.in_data  = v;
      for (int i = 0; i < 8; i++) q0.push_back(beat(v, 1'b0, i));
      @(negedge clk);
      bus0.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus0.in_valid = 1'b1;
      bus0.in_data  = 8'hC3;
      bus1.in_valid = 1'b1;
      bus1.in_data  = 8'hC3;
      repeat (2) @(negedge clk);
      total++;
      if ({bus0.in_ready, bus0.out_valid, bus0.out_last,
           bus0.out_parity, bus0.mux_a, bus0.mux_s} !== 15'd0)
         $display("FAIL reset_out0 rdy=%b vld=%b last=%b par=%b a=%h s=%0d required all 0",
                  bus0.in_ready, bus0.out_valid, bus0.out_last,
                  bus0.out_parity, bus0.mux_a, bus0.mux_s);
      else ok++;
      total++;
      if ({bus1.in_ready, bus1.out_valid, bus1.mux_a, bus1.mux_s} !== 13'd0)
         $display("FAIL reset_out1 rdy=%b vld=%b a=%h s=%0d required all 0",
                  bus1.in_ready, bus1.out_valid, bus1.mux_a, bus1.mux_s);
      else ok++;
      rst = 1'b0;
      bus0.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({bus0.in_ready, bus1.in_ready, bus0.out_valid} !== 3'b110)
         $display("FAIL reset_release got %b required 110",
                  {bus0.in_ready, bus1.in_ready, bus0.out_valid});
      else ok++;
   endtask

   task automatic test_lsb;
      exp_t       e;
      logic [6:0] got;
      int         beats;
      int         last_c;
      int         rdy_c;
      beats = 0;
      last_c = 0;
      rdy_c = 0;
      bus0.out_ready = 1'b1;
      offer0(8'b0110_1111);
      for (int c = 1; c <= 12; c++) begin
         if (bus0.out_valid && bus0.out_ready) begin
            total++;
            got = {bus0.in_ready, bus0.out_bit, bus0.out_last,
                   bus0.out_parity, bus0.mux_s};
            if (q0.size() == 0) begin
               $display("FAIL lsb_extra got %b required none", got);
            end else begin
               e = q0.pop_front();
               if (got !== {1'b0, e})
                  $display("FAIL lsb_beat%0d got %b required %b",
                           beats, got, {1'b0, e});
               else ok++;
            end
            beats++;
            if (bus0.out_last) last_c = c;
         end
         if (bus0.in_ready && rdy_c == 0) rdy_c = c;
         @(negedge clk);
      end
      total++;
      if ({beats, last_c, rdy_c} !== {32'd8, 32'd8, 32'd9})
         $display("FAIL lsb_timing beats=%0d last=%0d ready=%0d required 8 8 9",
                  beats, last_c, rdy_c);
      else ok++;
   endtask

   task automatic test_msb;
      exp_t       e;
      logic [6:0] got;
      int         beats;
      int         rdy_c;
      beats = 0;
      rdy_c = 0;
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.in_data  = 8'b0110_1111;
      for (int i = 0; i < 8; i++) q1.push_back(beat(8'b0110_1111, 1'b1, i));
      @(negedge clk);
      bus1.in_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (bus1.out_valid && bus1.out_ready) begin
            total++;
            got = {bus1.in_ready, bus1.out_bit, bus1.out_last,
                   bus1.out_parity, bus1.mux_s};
            if (q1.size() == 0) begin
               $display("FAIL msb_extra got %b required none", got);
            end else begin
               e = q1.pop_front();
               if (got !== {1'b0, e})
                  $display("FAIL msb_beat%0d got %b required %b",
                           beats, got, {1'b0, e});
               else ok++;
            end
            beats++;
         end
         if (bus1.in_ready && rdy_c == 0) rdy_c = c;
         @(negedge clk);
      end
      total++;
      if ({beats, rdy_c} !== {32'd8, 32'd9})
         $display("FAIL msb_timing beats=%0d ready=%0d required 8 9",
                  beats, rdy_c);
      else ok++;
   endtask

   task automatic test_backpressure;
      exp_t       e;
      logic [6:0] got;
      logic [5:0] held;
      logic [5:0] now;
      logic       stalled;
      int         beats;
      beats = 0;
      stalled = 1'b0;
      held = '0;
      bus0.out_ready = 1'b1;
      offer0(8'hA5);
      for (int k = 0; k < 40; k++) begin
         bus0.out_ready = (k % 4 == 0) || (k % 4 == 3);
         now = {bus0.out_valid, bus0.out_bit, bus0.out_last,
                bus0.out_parity, bus0.mux_s[1:0]};
         if (stalled) begin
            total++;
            if (now !== held || bus0.mux_s !== e[2:0])
               $display("FAIL bp_stall got %b s=%0d required %b s=%0d",
                        now, bus0.mux_s, held, e[2:0]);
            else ok++;
         end
         if (bus0.out_valid && bus0.out_ready) begin
            total++;
            got = {bus0.in_ready, bus0.out_bit, bus0.out_last,
                   bus0.out_parity, bus0.mux_s};
            if (q0.size() == 0) begin
               $display("FAIL bp_extra got %b required none", got);
            end else begin
               e = q0.pop_front();
               if (got !== {1'b0, e})
                  $display("FAIL bp_beat%0d got %b required %b",
                           beats, got, {1'b0, e});
               else ok++;
            end
            beats++;
         end
         stalled = bus0.out_valid && !bus0.out_ready;
         if (stalled && q0.size() > 0) e = q0[0];
         held = now;
         @(negedge clk);
      end
      bus0.out_ready = 1'b1;
      total++;
      if (beats !== 8 || q0.size() != 0)
         $display("FAIL bp_count beats=%0d left=%0d required 8 0",
                  beats, q0.size());
      else ok++;
   endtask

   task automatic test_busy;
      exp_t       e;
      logic [6:0] got;
      int         beats;
      beats = 0;
      bus0.out_ready = 1'b1;
      offer0(8'h3C);
      for (int c = 0; c < 20 && beats < 8; c++) begin
         bus0.in_valid = 1'b1;
         bus0.in_data  = 8'($urandom);
         if (bus0.out_valid) begin
            total++;
            if (bus0.mux_a !== 8'h3C)
               $display("FAIL busy_mux_a got %h required 3c", bus0.mux_a);
            else ok++;
         end
         if (bus0.out_valid && bus0.out_ready) begin
            total++;
            got = {bus0.in_ready, bus0.out_bit, bus0.out_last,
                   bus0.out_parity, bus0.mux_s};
            if (q0.size() == 0) begin
               $display("FAIL busy_extra got %b required none", got);
            end else begin
               e = q0.pop_front();
               if (got !== {1'b0, e})
                  $display("FAIL busy_beat%0d got %b required %b",
                           beats, got, {1'b0, e});
               else ok++;
            end
            beats++;
            if (bus0.out_last) bus0.in_data = 8'h5A;
         end
         @(negedge clk);
      end
      total++;
      if ({bus0.in_ready, bus0.out_valid, bus0.mux_a} !== {2'b10, 8'h3C})
         $display("FAIL busy_idle rdy=%b vld=%b a=%h required 1 0 3c",
                  bus0.in_ready, bus0.out_valid, bus0.mux_a);
      else ok++;
      for (int i = 0; i < 8; i++) q0.push_back(beat(8'h5A, 1'b0, i));
      @(negedge clk);
      bus0.in_valid = 1'b0;
      total++;
      if ({bus0.out_valid, bus0.mux_a} !== {1'b1, 8'h5A})
         $display("FAIL busy_next vld=%b a=%h required 1 5a",
                  bus0.out_valid, bus0.mux_a);
      else ok++;
      for (int c = 0; c < 12; c++) begin
         if (bus0.out_valid && bus0.out_ready) begin
            total++;
            got = {bus0.in_ready, bus0.out_bit, bus0.out_last,
                   bus0.out_parity, bus0.mux_s};
            if (q0.size() == 0) begin
               $display("FAIL busy2_extra got %b required none", got);
            end else begin
               e = q0.pop_front();
               if (got !== {1'b0, e})
                  $display("FAIL busy2_beat got %b required %b",
                           got, {1'b0, e});
               else ok++;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      exp_t       e;
      logic [6:0] got;
      int         beats;
      beats = 0;
      bus0.out_ready = 1'b1;
      offer0(8'hFF);
      for (int c = 0; c < 10 && beats < 3; c++) begin
         if (bus0.out_valid && bus0.out_ready) begin
            total++;
            got = {bus0.in_ready, bus0.out_bit, bus0.out_last,
                   bus0.out_parity, bus0.mux_s};
            e = q0.pop_front();
            if (got !== {1'b0, e})
               $display("FAIL rmid_beat%0d got %b required %b",
                        beats, got, {1'b0, e});
            else ok++;
            beats++;
         end
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({bus0.out_valid, bus0.out_last, bus0.mux_a, bus0.mux_s} !== 13'd0)
         $display("FAIL rmid_state vld=%b last=%b a=%h s=%0d required 0 0 00 0",
                  bus0.out_valid, bus0.out_last, bus0.mux_a, bus0.mux_s);
      else ok++;
      q0.delete();
      rst = 1'b0;
      offer0(8'h01);
      for (int c = 0; c < 12; c++) begin
         if (bus0.out_valid && bus0.out_ready) begin
            total++;
            got = {bus0.in_ready, bus0.out_bit, bus0.out_last,
                   bus0.out_parity, bus0.mux_s};
            if (q0.size() == 0) begin
               $display("FAIL rmid_extra got %b required none", got);
            end else begin
               e = q0.pop_front();
               if (got !== {1'b0, e})
                  $display("FAIL rmid_new got %b required %b",
                           got, {1'b0, e});
               else ok++;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_odd_parity;
      exp_t       e;
      logic [6:0] got;
      bus0.out_ready = 1'b1;
      offer0(8'h07);
      for (int c = 0; c < 12; c++) begin
         if (bus0.out_valid && bus0.out_ready) begin
            total++;
            got = {bus0.in_ready, bus0.out_bit, bus0.out_last,
                   bus0.out_parity, bus0.mux_s};
            if (q0.size() == 0) begin
               $display("FAIL odd_extra got %b required none", got);
            end else begin
               e = q0.pop_front();
               if (got !== {1'b0, e})
                  $display("FAIL odd_beat got %b required %b",
                           got, {1'b0, e});
               else ok++;
            end
         end
         @(negedge clk);
      end
      total++;
      if (q0.size() != 0)
         $display("FAIL odd_left got %0d required 0", q0.size());
      else ok++;
   endtask

   initial begin
      ok = 0;
      total = 0;
      rst = 1'b1;
      bus0.in_valid = 1'b0;
      bus0.in_data = 8'h00;
      bus0.out_ready = 1'b0;
      bus1.in_valid = 1'b0;
      bus1.in_data = 8'h00;
      bus1.out_ready = 1'b0;
      test_reset();
      test_lsb();
      test_msb();
      test_backpressure();
      test_busy();
      test_reset_mid();
      test_odd_parity();
      $display("%0d/%0d checks passed", ok, total);
      $finish;
   end

endmodule

// File: doc/etomux_seq_driver.md
# etomux_seq_driver

Sequencer that sits directly upstream of the 8-to-1 behavioural multiplexer (`etomux`) and turns it into a byte serializer. It accepts one byte over a valid/ready handshake, holds it on the mux data inputs and steps the mux select through all eight positions. Each mux output bit is forwarded downstream as one beat of a valid/ready bit stream, with a last-beat flag and running even parity.

## Interface
- `MSB_FIRST`, default 0: 0 = select counts 0→7 (bit 0 first); 1 = select counts 7→0 (bit 7 first).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream byte available.
- `in_ready`  output  1  block can accept a byte.
- `in_data`  input  8  byte to serialize.
- `mux_a`  output  8  registered byte driven to the mux `a` input.
- `mux_s`  output  3  registered select driven to the mux `s` input.
- `mux_q`  input  1  mux output; combinational function of `mux_a`/`mux_s`.
- `out_bit`  output  1  current serial bit; equals `mux_q`.
- `out_valid`  output  1  `out_bit` is valid.
- `out_ready`  input  1  downstream accepts the beat.
- `out_last`  output  1  high on the 8th beat of a byte.
- `out_parity`  output  1  XOR of all 8 bits of the byte; valid only when `out_last`=1, 0 otherwise.

## Operation
- The FSM has two states, IDLE and SEND.
- **IDLE**
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`: latch `in_data` into `mux_a`.
  - Load `mux_s` with 0 (`MSB_FIRST`=0) or 7 (`MSB_FIRST`=1).
  - Clear the beat counter `cnt` to 0 and the parity accumulator `par` to 0, then go to SEND.
- **SEND**
  - `in_ready`=0, `out_valid`=1, `out_bit`=`mux_q`.
  - `out_last`=(`cnt`==7).
  - `out_parity`=`par` ^ `mux_q` when `out_last`=1, else 0.
  - On `out_valid && out_ready` with `cnt`<7: `cnt`+=1; `mux_s`+=1 (`MSB_FIRST`=0) or `mux_s`-=1 (`MSB_FIRST`=1); `par`^=`mux_q`.
  - On `out_valid && out_ready` with `cnt`==7: go to IDLE. `mux_a` keeps its value, and `mux_s` keeps its final value (7 or 0).
  - While `out_ready`=0: all state holds and `out_bit`, `out_last` and `out_parity` stay stable.
- `mux_a` changes only on an accepted input byte and never changes during SEND.
- `cnt` is 3 bits and never wraps inside a byte. The SEND→IDLE exit happens exactly at `cnt`==7.
- `in_valid` is ignored in SEND, so `in_data` is not sampled there.
- **Reset**, applied on any edge with `rst`=1 and overriding all else, including mid-byte:
  - State IDLE; `mux_a`=8'h00, `mux_s`=3'b000, `cnt`=0, `par`=0.
  - A byte in flight is dropped and no `out_last` is produced for it.
- **Outputs while `rst`=1**: `in_ready`=0, `out_valid`=0, `out_last`=0, `out_parity`=0. The block does not honour handshakes during reset.
- **First cycle after `rst` falls**: `in_ready`=1.

## Timing
- Input acceptance is 1 cycle. `out_valid` rises in the cycle after the accepting edge, and the first bit is on `out_bit` in that same cycle.
- The mux is combinational, so `out_bit` settles in the same cycle `mux_s` updates. No extra capture stage.
- With `out_ready` held high, one bit is delivered per cycle. A byte takes 8 SEND cycles plus 1 IDLE cycle, so back-to-back bytes run at 9 cycles per byte.
- `in_ready` is 0 on every SEND cycle, including the last-beat cycle. It returns to 1 the cycle after the last beat is accepted.
- Backpressure can stall any beat for any number of cycles, with no loss or duplication of bits.

## Test plan
- **Basic LSB-first stream**
  - Stimulus: reset, then `in_data`=8'b01101111, `out_ready`=1, `MSB_FIRST`=0.
  - Required: `mux_s` steps 0..7 on consecutive cycles; `out_bit` sequence is 1,1,1,1,0,1,1,0.
  - `out_last` is high only on beat 8, with `out_parity`=0 there; `in_ready` is back to 1 nine cycles after acceptance.
- **MSB-first**
  - Stimulus: same byte with `MSB_FIRST`=1.
  - Required: `mux_s` steps 7..0; bits are 0,1,1,0,1,1,1,1.
- **Backpressure**
  - Stimulus: 8'hA5 with `out_ready` toggling 1,0,0,1,…
  - Required: exactly 8 accepted beats, bits 1,0,1,0,0,1,0,1 (LSB first); `out_bit`/`mux_s` stable while stalled; `out_parity`=0 on the last beat.
- **Ignored input while busy**
  - Stimulus: hold `in_valid`=1 with `in_data` changing during SEND.
  - Required: `mux_a` unchanged; the next byte is accepted only in the IDLE cycle after `out_last`.
- **Reset mid-byte**
  - Stimulus: 8'hFF, assert `rst` after beat 3.
  - Required: next edge gives `out_valid`=0, `mux_a`=8'h00, `mux_s`=0; a new byte 8'h01 then streams as 1,0,0,0,0,0,0,0 with `out_parity`=1.
- **Odd parity**
  - Stimulus: 8'h07.
  - Required: `out_parity`=1 on the last beat and 0 on all others.
